// File: rtl/tb_mem_responder_pkg.sv
// Shared widths, queue entry layout and helpers for the memory responder.
package tb_mem_responder_pkg;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned LAT_W  = 8;
  localparam int unsigned STAT_W = 32;
  localparam int unsigned LFSR_W = 16;

  localparam logic [DATA_W-1:0] SALT      = 64'hA5A5_0000_0000_5A5A;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 as bit positions 15,13,12,10.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              err;
    logic [LAT_W-1:0]  cnt;
  } resp_ent_t;

  function automatic logic [DATA_W-1:0] pte_of(input logic [ADDR_W-1:0] addr);
    return DATA_W'(addr) ^ SALT;
  endfunction

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/tb_mem_resp_chan.sv
// One responder channel: in-order latency queue, statistics and stall watchdog.
module tb_mem_resp_chan
  import tb_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TMO   = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_err,
  input  logic [LAT_W-1:0]  req_cnt,
  input  logic              bp_open,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_err,
  output logic [DATA_W-1:0] resp_data,
  output logic [STAT_W-1:0] stat_req,
  output logic [STAT_W-1:0] stat_resp,
  output logic              hang
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned STALL_W = $clog2(TMO + 1);

  resp_ent_t          ent_q [DEPTH];
  resp_ent_t          ent_d [DEPTH];
  resp_ent_t          head_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               push, pop;
  logic               req_ready_d, resp_valid_d, resp_err_d, hang_d;
  logic [DATA_W-1:0]  resp_data_d;
  logic [STAT_W-1:0]  stat_req_d, stat_resp_d;

  // Next state; outputs are registered from the post-edge queue view.
  always_comb begin
    push     = req_valid && req_ready;
    pop      = resp_valid && resp_ready;
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

    for (int unsigned i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      if (ent_q[i].cnt != '0) ent_d[i].cnt = ent_q[i].cnt - LAT_W'(1);
    end
    if (push) ent_d[wr_ptr_q] = '{addr: req_addr, err: req_err, cnt: req_cnt};

    // A freshly pushed head always has cnt >= 1, so it cannot go valid on its own edge.
    head_d       = ent_d[rd_ptr_d];
    resp_valid_d = (count_d != '0) && (head_d.cnt == '0);
    resp_err_d   = resp_valid_d && head_d.err;
    resp_data_d  = (resp_valid_d && !head_d.err) ? pte_of(head_d.addr) : '0;
    req_ready_d  = (count_d < CNT_W'(DEPTH)) && bp_open;

    stat_req_d  = stat_req + STAT_W'(push);
    stat_resp_d = stat_resp + STAT_W'(pop);

    stall_d = stall_q;
    if (pop) begin
      stall_d = '0;
    end else if (resp_valid && !resp_ready && (stall_q != STALL_W'(TMO))) begin
      stall_d = stall_q + STALL_W'(1);
    end
    hang_d = hang || (stall_d == STALL_W'(TMO));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ent_q      <= '{default: '0};
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      stall_q    <= '0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_data  <= '0;
      stat_req   <= '0;
      stat_resp  <= '0;
      hang       <= 1'b0;
    end else begin
      ent_q      <= ent_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      stall_q    <= stall_d;
      req_ready  <= req_ready_d;
      resp_valid <= resp_valid_d;
      resp_err   <= resp_err_d;
      resp_data  <= resp_data_d;
      stat_req   <= stat_req_d;
      stat_resp  <= stat_resp_d;
      hang       <= hang_d;
    end
  end

endmodule

// File: rtl/tb_mem_responder.sv
// Multi-channel memory responder: shared LFSR and config decode around NCH channels.
module tb_mem_responder
  import tb_mem_responder_pkg::*;
#(
  parameter int unsigned NCH   = 2,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TMO   = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NCH-1:0]        req_valid,
  output logic [NCH-1:0]        req_ready,
  input  logic [NCH*ADDR_W-1:0] req_addr,
  output logic [NCH-1:0]        resp_valid,
  input  logic [NCH-1:0]        resp_ready,
  output logic [NCH-1:0]        resp_err,
  output logic [NCH*DATA_W-1:0] resp_data,
  input  logic [LAT_W-1:0]      cfg_lat,
  input  logic                  cfg_bp,
  input  logic [ADDR_W-1:0]     cfg_err_base,
  input  logic [ADDR_W-1:0]     cfg_err_mask,
  output logic [NCH*STAT_W-1:0] stat_req,
  output logic [NCH*STAT_W-1:0] stat_resp,
  output logic [NCH-1:0]        hang
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [LAT_W-1:0]  lat_eff;
  logic              err_en;

  always_comb begin
    lfsr_d  = lfsr_step(lfsr_q);
    lat_eff = (cfg_lat == '0) ? LAT_W'(1) : cfg_lat;
    err_en  = (cfg_err_mask != '0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [ADDR_W-1:0] addr;
    logic              err_hit;
    logic              bp_open;

    assign addr    = req_addr[c*ADDR_W +: ADDR_W];
    assign err_hit = err_en && ((addr & cfg_err_mask) == (cfg_err_base & cfg_err_mask));
    // Ready is registered, so gate it with the LFSR value it will be paired with.
    assign bp_open = !cfg_bp || lfsr_d[c];

    tb_mem_resp_chan #(
      .DEPTH (DEPTH),
      .TMO   (TMO)
    ) u_chan (
      .clock      (clock),
      .reset      (reset),
      .req_valid  (req_valid[c]),
      .req_ready  (req_ready[c]),
      .req_addr   (addr),
      .req_err    (err_hit),
      .req_cnt    (lat_eff),
      .bp_open    (bp_open),
      .resp_valid (resp_valid[c]),
      .resp_ready (resp_ready[c]),
      .resp_err   (resp_err[c]),
      .resp_data  (resp_data[c*DATA_W +: DATA_W]),
      .stat_req   (stat_req[c*STAT_W +: STAT_W]),
      .stat_resp  (stat_resp[c*STAT_W +: STAT_W]),
      .hang       (hang[c])
    );
  end

endmodule

// File: tb/tb_tb_mem_responder.sv
// Bench for tb_mem_responder: directed scenarios plus random traffic against a due-time model.
module tb_tb_mem_responder;

  localparam int unsigned NCH   = 2;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned TMO   = 16;
  localparam logic [63:0] SALT  = 64'hA5A5_0000_0000_5A5A;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic [NCH-1:0]     req_valid = '0;
  logic [NCH-1:0]     req_ready;
  logic [NCH*64-1:0]  req_addr = '0;
  logic [NCH-1:0]     resp_valid;
  logic [NCH-1:0]     resp_ready = '1;
  logic [NCH-1:0]     resp_err;
  logic [NCH*64-1:0]  resp_data;
  logic [7:0]         cfg_lat = 8'd4;
  logic               cfg_bp = 1'b0;
  logic [63:0]        cfg_err_base = '0;
  logic [63:0]        cfg_err_mask = '0;
  logic [NCH*32-1:0]  stat_req;
  logic [NCH*32-1:0]  stat_resp;
  logic [NCH-1:0]     hang;

  int n_assert = 0;
  int n_fail   = 0;

  tb_mem_responder #(.NCH(NCH), .DEPTH(DEPTH), .TMO(TMO)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_err     (resp_err),
    .resp_data    (resp_data),
    .cfg_lat      (cfg_lat),
    .cfg_bp       (cfg_bp),
    .cfg_err_base (cfg_err_base),
    .cfg_err_mask (cfg_err_mask),
    .stat_req     (stat_req),
    .stat_resp    (stat_resp),
    .hang         (hang)
  );

  always #5 clock = ~clock;

  // Model: each outstanding request remembers the edge at which it becomes answerable.
  typedef struct {
    logic [63:0] addr;
    bit          err;
    int          due;
  } ment_t;

  ment_t       mq [NCH][$];
  int          edge_n;
  logic [15:0] m_lfsr;
  bit          m_ready [NCH];
  int          m_stall [NCH];
  bit          m_hang  [NCH];
  logic [31:0] m_sreq  [NCH];
  logic [31:0] m_sresp [NCH];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_valid(int c);
    return (mq[c].size() > 0) && (edge_n >= mq[c][0].due);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      mq[c].delete();
      m_ready[c] = 0;
      m_stall[c] = 0;
      m_hang[c]  = 0;
      m_sreq[c]  = '0;
      m_sresp[c] = '0;
    end
    m_lfsr = 16'hACE1;
    edge_n = 0;
  endtask

  task automatic model_edge();
    bit push [NCH];
    bit pop  [NCH];
    bit v;
    ment_t e;
    int lat;
    for (int c = 0; c < NCH; c++) begin
      v       = exp_valid(c);
      push[c] = req_valid[c] && m_ready[c];
      pop[c]  = v && resp_ready[c];
      if (pop[c]) m_stall[c] = 0;
      else if (v && !resp_ready[c] && m_stall[c] < TMO) m_stall[c]++;
      if (m_stall[c] == TMO) m_hang[c] = 1;
    end
    edge_n++;
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    lat = (cfg_lat == 0) ? 1 : int'(cfg_lat);
    for (int c = 0; c < NCH; c++) begin
      if (pop[c]) begin
        void'(mq[c].pop_front());
        m_sresp[c]++;
      end
      if (push[c]) begin
        e.addr = req_addr[c*64 +: 64];
        e.err  = (cfg_err_mask != 0) && ((e.addr & cfg_err_mask) == (cfg_err_base & cfg_err_mask));
        e.due  = edge_n + lat;
        mq[c].push_back(e);
        m_sreq[c]++;
      end
      m_ready[c] = (mq[c].size() < DEPTH) && (!cfg_bp || m_lfsr[c]);
    end
  endtask

  task automatic check_outputs();
    bit v;
    for (int c = 0; c < NCH; c++) begin
      v = exp_valid(c);
      chk($sformatf("req_ready%0d@%0d", c, edge_n), 64'(req_ready[c]), 64'(m_ready[c]));
      chk($sformatf("resp_valid%0d@%0d", c, edge_n), 64'(resp_valid[c]), 64'(v));
      if (v) begin
        chk($sformatf("resp_err%0d@%0d", c, edge_n), 64'(resp_err[c]), 64'(mq[c][0].err));
        chk($sformatf("resp_data%0d@%0d", c, edge_n), resp_data[c*64 +: 64],
            mq[c][0].err ? 64'h0 : (mq[c][0].addr ^ SALT));
      end
      chk($sformatf("hang%0d@%0d", c, edge_n), 64'(hang[c]), 64'(m_hang[c]));
      chk($sformatf("stat_req%0d@%0d", c, edge_n), 64'(stat_req[c*32 +: 32]), 64'(m_sreq[c]));
      chk($sformatf("stat_resp%0d@%0d", c, edge_n), 64'(stat_resp[c*32 +: 32]), 64'(m_sresp[c]));
    end
  endtask

  // Called at a falling edge with inputs already set; returns at the next falling edge.
  task automatic cyc();
    check_outputs();
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'h0);
    chk({tag, "_resp_valid"}, 64'(resp_valid), 64'h0);
    chk({tag, "_resp_err"}, 64'(resp_err), 64'h0);
    chk({tag, "_resp_data0"}, resp_data[63:0], 64'h0);
    chk({tag, "_resp_data1"}, resp_data[127:64], 64'h0);
    chk({tag, "_stat_req"}, stat_req, 64'h0);
    chk({tag, "_stat_resp"}, stat_resp, 64'h0);
    chk({tag, "_hang"}, 64'(hang), 64'h0);
  endtask

  task automatic wait_valid(input int c, input int maxc, output bit ok);
    ok = 0;
    for (int i = 0; i < maxc; i++) begin
      if (resp_valid[c]) begin
        ok = 1;
        break;
      end
      cyc();
    end
    if (resp_valid[c]) ok = 1;
  endtask

  task automatic drain(input string tag, input int maxc);
    req_valid  = '0;
    resp_ready = '1;
    for (int i = 0; i < maxc; i++) begin
      if (mq[0].size() == 0 && mq[1].size() == 0) break;
      cyc();
    end
    cyc();
    chk({tag, "_drained"}, 64'(resp_valid), 64'h0);
  endtask

  initial begin
    bit          ok;
    int          acc;
    int          n;
    logic [31:0] base;
    logic [63:0] got [$];
    logic [63:0] a;

    model_reset();
    @(negedge clock);
    @(negedge clock);
    chk_all_zero("reset");
    reset = 1'b1;

    // Latency: one request at lat 4
    cfg_lat = 8'd4;
    for (int i = 0; i < 9; i++) cyc();
    req_valid[0] = 1'b1;
    req_addr[63:0] = 64'h1000;
    cyc();
    acc = edge_n;
    req_valid[0] = 1'b0;
    chk("t1_stat_req", 64'(stat_req[31:0]), 64'd1);
    wait_valid(0, 20, ok);
    chk("t1_seen", 64'(ok), 64'd1);
    chk("t1_latency", 64'(edge_n - acc), 64'd4);
    chk("t1_data", resp_data[63:0], 64'h1000 ^ SALT);
    chk("t1_err", 64'(resp_err[0]), 64'd0);
    drain("t1", 20);

    // Full queue at lat 50
    cfg_lat = 8'd50;
    base = stat_req[31:0];
    req_valid[0] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      req_addr[63:0] = 64'h2000 + 64'(i);
      cyc();
    end
    chk("t2_accepts", 64'(stat_req[31:0] - base), 64'd8);
    chk("t2_ready_low", 64'(req_ready[0]), 64'd0);
    wait_valid(0, 60, ok);
    chk("t2_seen", 64'(ok), 64'd1);
    cyc();
    chk("t2_ready_back", 64'(req_ready[0]), 64'd1);
    drain("t2", 300);

    // Error window
    cfg_lat      = 8'd3;
    cfg_err_base = 64'h8000;
    cfg_err_mask = 64'hF000;
    req_valid[0] = 1'b1;
    req_addr[63:0] = 64'h8010;
    cyc();
    req_addr[63:0] = 64'h9010;
    cyc();
    req_valid[0] = 1'b0;
    wait_valid(0, 20, ok);
    chk("t3_seen_a", 64'(ok), 64'd1);
    chk("t3_err_a", 64'(resp_err[0]), 64'd1);
    chk("t3_data_a", resp_data[63:0], 64'h0);
    cyc();
    wait_valid(0, 20, ok);
    chk("t3_seen_b", 64'(ok), 64'd1);
    chk("t3_err_b", 64'(resp_err[0]), 64'd0);
    chk("t3_data_b", resp_data[63:0], 64'h9010 ^ SALT);
    drain("t3", 20);
    cfg_err_mask = '0;

    // Reset with three entries in flight
    cfg_lat = 8'd20;
    req_valid[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_addr[63:0] = 64'h3000 + 64'(i);
      cyc();
    end
    req_valid[0] = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
    #1;
    chk_all_zero("t6_async");
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      if (resp_valid[0]) n++;
      cyc();
    end
    chk("t6_no_stale", 64'(n), 64'd0);

    // Order under toggling resp_ready
    cfg_lat = 8'd2;
    for (int i = 0; i < 4; i++) begin
      req_valid[0] = 1'b1;
      req_addr[63:0] = 64'h4000 + 64'(i * 8);
      resp_ready[0] = i[0];
      if (resp_valid[0] && resp_ready[0]) got.push_back(resp_data[63:0]);
      cyc();
    end
    req_valid[0] = 1'b0;
    for (int i = 0; i < 30; i++) begin
      resp_ready[0] = i[0];
      if (resp_valid[0] && resp_ready[0]) got.push_back(resp_data[63:0]);
      cyc();
    end
    chk("t4_count", 64'(got.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      a = (i < got.size()) ? got[i] : 64'hX;
      chk($sformatf("t4_order%0d", i), a, (64'h4000 + 64'(i * 8)) ^ SALT);
    end
    drain("t4", 20);
    chk("t4_stat_req", 64'(stat_req[31:0]), 64'd4);
    chk("t4_stat_resp", 64'(stat_resp[31:0]), 64'd4);

    // Watchdog with resp_ready held low
    cfg_lat = 8'd1;
    resp_ready[0] = 1'b0;
    req_valid[0] = 1'b1;
    req_addr[63:0] = 64'h5000;
    cyc();
    req_valid[0] = 1'b0;
    wait_valid(0, 10, ok);
    chk("t5_seen", 64'(ok), 64'd1);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc();
      if (hang[0]) begin
        n = i;
        break;
      end
    end
    chk("t5_hang_delay", 64'(n), 64'd16);
    resp_ready[0] = 1'b1;
    cyc();
    cyc();
    chk("t5_hang_sticky", 64'(hang[0]), 64'd1);
    drain("t5", 20);

    // Random traffic on both channels
    cfg_err_base = 64'h30;
    cfg_err_mask = 64'hF0;
    for (int i = 0; i < 2000; i++) begin
      if (i % 100 == 0) begin
        cfg_bp  = 1'($urandom_range(0, 1));
        cfg_lat = 8'($urandom_range(0, 6));
      end
      for (int c = 0; c < NCH; c++) begin
        req_valid[c]  = ($urandom_range(0, 3) != 0);
        resp_ready[c] = ($urandom_range(0, 3) != 0);
        req_addr[c*64 +: 64] = {$urandom, $urandom};
      end
      cyc();
    end
    drain("rand", 200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
